// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register.
//   pipe_state_t : control FSM state; the encoding doubles as the occupancy count.
//   occ_of()     : maps a state onto the 2-bit occupancy output.
package pipe_pkg;

   localparam int unsigned OCC_W = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_t;

   function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
      return OCC_W'(s);
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// One N-bit payload storage element with load enable.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset, loads RESET_VAL
//   load_i : capture d_i on the next clock edge
//   d_i    : payload to capture
//   q_o    : stored payload
module pipe_entry #(
   parameter int unsigned   N         = 24,
   parameter logic [N-1:0]  RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [N-1:0] d_i,
   output logic [N-1:0] q_o
);

   logic [N-1:0] data_q;

   // Storage register; holds unless explicitly loaded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= RESET_VAL;
      end else if (load_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/pipe_register.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Back-pressure is absorbed by the skid entry so in_ready never depends
// combinationally on out_ready.
//   clk, rst            : clock, asynchronous active-low reset
//   flush               : synchronous discard of every held entry
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//   occupancy           : number of entries held (0..2)
module pipe_register
   import pipe_pkg::*;
#(
   parameter int unsigned   N         = 24,
   parameter logic [N-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [OCC_W-1:0] occupancy
);

   pipe_state_t  state_q, state_d;
   logic         in_ready_q, out_valid_q;
   logic         in_fire_c, out_fire_c;
   logic         main_load_c, skid_load_c, main_from_skid_c;
   logic [N-1:0] main_d, main_q, skid_q;

   assign in_fire_c  = in_valid & in_ready_q;
   assign out_fire_c = out_valid_q & out_ready;

   // Next-state and entry load decisions; flush wins and suppresses all loads.
   always_comb begin
      state_d          = state_q;
      main_load_c      = 1'b0;
      skid_load_c      = 1'b0;
      main_from_skid_c = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire_c) begin
                  main_load_c = 1'b1;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (in_fire_c && out_fire_c) begin
                  main_load_c = 1'b1;
               end else if (in_fire_c) begin
                  skid_load_c = 1'b1;
                  state_d     = FULL;
               end else if (out_fire_c) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire_c) begin
                  main_load_c      = 1'b1;
                  main_from_skid_c = 1'b1;
                  state_d          = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Main refills from the skid only when draining out of FULL.
   assign main_d = main_from_skid_c ? skid_q : in_data;

   // State plus handshake flags, all flopped so outputs carry no input paths.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != FULL);
         out_valid_q <= (state_d != EMPTY);
      end
   end

   pipe_entry #(.N(N), .RESET_VAL(RESET_VAL)) u_main (
      .clk    (clk),
      .rst    (rst),
      .load_i (main_load_c),
      .d_i    (main_d),
      .q_o    (main_q)
   );

   pipe_entry #(.N(N), .RESET_VAL(RESET_VAL)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load_i (skid_load_c),
      .d_i    (in_data),
      .q_o    (skid_q)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = occ_of(state_q);

endmodule
